// File: rtl/ula_ctrl.sv
// Multi-cycle controller for the 8-bit ULA: one instruction per handshake, 4x8 register file,
// IDLE -> DECODE -> EXEC -> WB sequence with registered operands and status.
module ula_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InstrValid,
  input  logic [15:0] Instr,
  output logic        InstrReady,
  output logic [7:0]  SrcA,
  output logic [7:0]  SrcB,
  output logic [2:0]  ULAControl,
  input  logic [7:0]  ULAResult,
  input  logic        Flag_z,
  input  logic        CarryOut,
  output logic        Done,
  output logic        Z,
  output logic        C,
  output logic        Err,
  input  logic [1:0]  RegSel,
  output logic [7:0]  RegData
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpLdi = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpIll = 3'b111;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic [7:0]  src_a_q, src_a_d;
  logic [7:0]  src_b_q, src_b_d;
  logic [2:0]  ula_ctrl_q, ula_ctrl_d;
  logic [7:0]  result_q, result_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic        err_q, err_d;

  // Instruction fields; rt and imm8 overlap on bit 7 by design.
  logic [2:0] opcode;
  logic [1:0] rd, rs, rt;
  logic [7:0] imm8;
  logic       is_alu;

  assign opcode = instr_q[15:13];
  assign rd     = instr_q[12:11];
  assign rs     = instr_q[10:9];
  assign rt     = instr_q[8:7];
  assign imm8   = instr_q[7:0];

  always_comb begin
    is_alu = 1'b0;
    unique case (opcode)
      OpAdd, OpSub, OpAnd, OpOr, OpSlt: is_alu = 1'b1;
      default:                          is_alu = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (InstrValid) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    instr_d    = instr_q;
    regs_d     = regs_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    ula_ctrl_d = ula_ctrl_q;
    result_d   = result_q;
    z_d        = z_q;
    c_d        = c_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (InstrValid) instr_d = Instr;
      end
      StDecode: begin
        if (is_alu) begin
          src_a_d    = regs_q[rs];
          src_b_d    = regs_q[rt];
          ula_ctrl_d = opcode;
        end
      end
      StExec: begin
        if (is_alu) begin
          result_d = ULAResult;
          z_d      = Flag_z;
          c_d      = CarryOut;
        end else if (opcode == OpLdi) begin
          result_d = imm8;
        end else if (opcode == OpIll) begin
          err_d = 1'b1;
        end
      end
      StWb: begin
        if (is_alu || opcode == OpLdi) regs_d[rd] = result_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q    <= '0;
      regs_q     <= '{default: '0};
      src_a_q    <= '0;
      src_b_q    <= '0;
      ula_ctrl_q <= '0;
      result_q   <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      regs_q     <= regs_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      ula_ctrl_q <= ula_ctrl_d;
      result_q   <= result_d;
      z_q        <= z_d;
      c_q        <= c_d;
      err_q      <= err_d;
    end
  end

  // Outputs
  always_comb begin
    InstrReady = (state_q == StIdle);
    Done       = (state_q == StWb);
    SrcA       = src_a_q;
    SrcB       = src_b_q;
    ULAControl = ula_ctrl_q;
    Z          = z_q;
    C          = c_q;
    Err        = err_q;
    RegData    = regs_q[RegSel];
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// Self-checking bench for ula_ctrl: behavioural ULA stub plus an instruction-level reference
// model of the register file and status flags, directed and randomized scenarios.
module tb_ula_ctrl;

  logic        clk;
  logic        rst_n;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic [7:0]  SrcA, SrcB;
  logic [2:0]  ULAControl;
  logic [7:0]  ULAResult;
  logic        Flag_z, CarryOut;
  logic        Done, Z, C, Err;
  logic [1:0]  RegSel;
  logic [7:0]  RegData;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_accept = 0;

  // Reference model state
  logic [7:0] m_regs [4];
  logic       m_z, m_c, m_err;
  logic [7:0] m_a, m_b;
  logic [2:0] m_ctrl;

  ula_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrReady (InstrReady),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ULAControl (ULAControl),
    .ULAResult  (ULAResult),
    .Flag_z     (Flag_z),
    .CarryOut   (CarryOut),
    .Done       (Done),
    .Z          (Z),
    .C          (C),
    .Err        (Err),
    .RegSel     (RegSel),
    .RegData    (RegData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ULA: returns {carry, result}
  function automatic logic [8:0] ula_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {(a < b), 8'(a - b)};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b101:  return {1'b0, 7'd0, (a < b)};
      default: return 9'd0;
    endcase
  endfunction

  always_comb begin
    {CarryOut, ULAResult} = ula_ref(ULAControl, SrcA, SrcB);
    Flag_z = (ULAResult == 8'd0);
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt, 7'd0};
  endfunction

  function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b100, rd, 3'b000, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
    m_z = 0; m_c = 0; m_err = 0; m_a = 0; m_b = 0; m_ctrl = 0;
  endtask

  // Drives one instruction through the full handshake; entered and left at a falling edge.
  task automatic drive_instr(input logic [15:0] ins, input bit keep_valid, input bit check_gap);
    int waited = 0;
    logic [2:0] op;
    logic [8:0] r;
    logic [7:0] exp_reg;
    op = ins[15:13];
    Instr = ins;
    InstrValid = 1'b1;
    while (InstrReady !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (InstrReady !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: InstrReady=%b required 1", InstrReady);
      InstrValid = 1'b0;
      return;
    end
    // Model update at instruction level
    if (op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101}) begin
      m_a = m_regs[ins[10:9]];
      m_b = m_regs[ins[8:7]];
      m_ctrl = op;
      r = ula_ref(op, m_a, m_b);
      m_regs[ins[12:11]] = r[7:0];
      m_c = r[8];
      m_z = (r[7:0] == 8'd0);
    end else if (op == 3'b100) begin
      m_regs[ins[12:11]] = ins[7:0];
    end else if (op == 3'b111) begin
      m_err = 1'b1;
    end

    @(negedge clk);  // DECODE
    if (check_gap) begin
      checks++;
      if (cyc - last_accept !== 4) begin
        failures++;
        $display("FAIL accept_gap: gap=%0d required 4", cyc - last_accept);
      end
    end
    last_accept = cyc;
    Instr = 16'($urandom);
    checks++;
    if (InstrReady !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL decode_hs: ready=%b done=%b required 0 0", InstrReady, Done);
    end

    @(negedge clk);  // EXEC
    Instr = 16'($urandom);
    checks++;
    if (InstrReady !== 1'b0 || Done !== 1'b0 || SrcA !== m_a || SrcB !== m_b ||
        ULAControl !== m_ctrl) begin
      failures++;
      $display("FAIL exec_ops: ready=%b done=%b a=%h b=%h ctl=%h required 0 0 %h %h %h",
               InstrReady, Done, SrcA, SrcB, ULAControl, m_a, m_b, m_ctrl);
    end

    @(negedge clk);  // WB
    checks++;
    if (Done !== 1'b1 || InstrReady !== 1'b0) begin
      failures++;
      $display("FAIL wb_done: done=%b ready=%b required 1 0", Done, InstrReady);
    end

    @(negedge clk);  // IDLE again
    InstrValid = keep_valid;
    checks++;
    if (InstrReady !== 1'b1 || Done !== 1'b0 || Z !== m_z || C !== m_c || Err !== m_err) begin
      failures++;
      $display("FAIL post_status: ready=%b done=%b z=%b c=%b err=%b required 1 0 %b %b %b",
               InstrReady, Done, Z, C, Err, m_z, m_c, m_err);
    end
    for (int i = 0; i < 4; i++) begin
      RegSel = 2'(i);
      #1;
      exp_reg = m_regs[i];
      checks++;
      if (RegData !== exp_reg) begin
        failures++;
        $display("FAIL regfile r%0d: got %h required %h", i, RegData, exp_reg);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; InstrValid = 1'b0; Instr = 16'd0; RegSel = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (Done !== 1'b0 || SrcA !== 8'd0 || SrcB !== 8'd0 || ULAControl !== 3'd0 ||
        Z !== 1'b0 || C !== 1'b0 || Err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: done=%b a=%h b=%h ctl=%h z=%b c=%b err=%b required zeros",
               Done, SrcA, SrcB, ULAControl, Z, C, Err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (InstrReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b required 1", InstrReady);
    end
    for (int i = 0; i < 4; i++) begin
      RegSel = 2'(i);
      #1;
      checks++;
      if (RegData !== 8'd0) begin
        failures++;
        $display("FAIL reset_reg r%0d: got %h required 00", i, RegData);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    drive_instr(mk_ldi(2'd1, 8'hC8), 1'b0, 1'b0);
    drive_instr(mk_ldi(2'd2, 8'h64), 1'b0, 1'b0);
    drive_instr(mk(3'b000, 2'd3, 2'd1, 2'd2), 1'b0, 1'b0);
    @(negedge clk);
    RegSel = 2'd3; #1;
    checks++;
    if (RegData !== 8'h2C || C !== 1'b1 || Z !== 1'b0) begin
      failures++;
      $display("FAIL add_const: r3=%h c=%b z=%b required 2c 1 0", RegData, C, Z);
    end
    drive_instr(mk(3'b001, 2'd0, 2'd2, 2'd2), 1'b0, 1'b0);
    drive_instr(mk(3'b001, 2'd1, 2'd2, 2'd1), 1'b0, 1'b0);
    @(negedge clk);
    RegSel = 2'd1; #1;
    checks++;
    if (RegData !== 8'h9C || C !== 1'b1 || Z !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow: r1=%h c=%b z=%b required 9c 1 0", RegData, C, Z);
    end
    drive_instr(mk_ldi(2'd1, 8'hC8), 1'b0, 1'b0);
    drive_instr(mk(3'b101, 2'd3, 2'd2, 2'd1), 1'b0, 1'b0);
    drive_instr(mk(3'b101, 2'd3, 2'd1, 2'd2), 1'b0, 1'b0);
    @(negedge clk);
    RegSel = 2'd3; #1;
    checks++;
    if (RegData !== 8'h00 || Z !== 1'b1 || C !== 1'b0) begin
      failures++;
      $display("FAIL slt_false: r3=%h z=%b c=%b required 00 1 0", RegData, Z, C);
    end
    drive_instr(mk(3'b010, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0);
    drive_instr(mk(3'b011, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0);
    @(negedge clk);
    RegSel = 2'd0; #1;
    checks++;
    if (RegData !== 8'hEC) begin
      failures++;
      $display("FAIL or_const: r0=%h required ec", RegData);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    drive_instr(16'hE000 | 16'($urandom_range(0, 16'h1FFF)), 1'b0, 1'b0);
    drive_instr(mk(3'b110, 2'd2, 2'd0, 2'd1), 1'b0, 1'b0);
    drive_instr(mk_ldi(2'd0, 8'h5A), 1'b0, 1'b0);
    checks++;
    if (Err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b required 1", Err);
    end
  endtask

  task automatic test_back_to_back();
    drive_instr(mk_ldi(2'd3, 8'h11), 1'b1, 1'b0);
    drive_instr(mk(3'b000, 2'd2, 2'd3, 2'd3), 1'b1, 1'b1);
    drive_instr(mk(3'b001, 2'd1, 2'd2, 2'd3), 1'b0, 1'b1);
  endtask

  task automatic test_random();
    bit prev_keep = 1'b0;
    bit keep;
    logic [15:0] ins;
    for (int n = 0; n < 40; n++) begin
      keep = (n == 39) ? 1'b0 : 1'($urandom);
      ins = 16'($urandom);
      drive_instr(ins, keep, prev_keep);
      prev_keep = keep;
    end
  endtask

  task automatic test_reset_mid();
    drive_instr(mk_ldi(2'd2, 8'h55), 1'b0, 1'b0);
    Instr = mk(3'b000, 2'd2, 2'd2, 2'd2);
    InstrValid = 1'b1;
    @(negedge clk);  // DECODE
    InstrValid = 1'b0;
    @(negedge clk);  // EXEC
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (InstrReady !== 1'b1 || Done !== 1'b0 || SrcA !== 8'd0 || SrcB !== 8'd0 ||
        ULAControl !== 3'd0 || Z !== 1'b0 || C !== 1'b0 || Err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_out: ready=%b done=%b a=%h b=%h ctl=%h z=%b c=%b err=%b req 1 0s",
               InstrReady, Done, SrcA, SrcB, ULAControl, Z, C, Err);
    end
    for (int i = 0; i < 4; i++) begin
      RegSel = 2'(i);
      #1;
      checks++;
      if (RegData !== 8'd0) begin
        failures++;
        $display("FAIL midreset_reg r%0d: got %h required 00", i, RegData);
      end
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (Done !== 1'b0) begin
        failures++;
        $display("FAIL midreset_done: got %b required 0", Done);
      end
    end
    drive_instr(mk_ldi(2'd1, 8'h7E), 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Multi-cycle controller that drives the 8-bit ULA from the other end of its operand/opcode interface. It accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal 4x8 register file. It presents `SrcA`/`SrcB`/`ULAControl` to the ULA, captures `ULAResult`/`Flag_z`/`CarryOut`, and writes the result back. It sits between the instruction source and the combinational ULA in the datapath.

## Interface

Parameters:
- none; data width is fixed at 8 bits, register file at 4 entries.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `InstrValid`  in  1  instruction on `Instr` is valid
- `Instr`  in  16  `[15:13]` opcode, `[12:11]` rd, `[10:9]` rs, `[8:7]` rt, `[7:0]` imm8 (LDI only)
- `InstrReady`  out  1  controller can accept an instruction
- `SrcA`  out  8  ULA operand A (registered)
- `SrcB`  out  8  ULA operand B (registered)
- `ULAControl`  out  3  ULA operation code (registered)
- `ULAResult`  in  8  ULA result (combinational from ULA)
- `Flag_z`  in  1  ULA zero flag
- `CarryOut`  in  1  ULA bit-8 carry/borrow
- `Done`  out  1  one-cycle pulse: instruction retired
- `Z`  out  1  registered zero status
- `C`  out  1  registered carry status
- `Err`  out  1  sticky illegal-opcode flag
- `RegSel`  in  2  debug read address
- `RegData`  out  8  combinational read of `regs[RegSel]`

## Operation

- Opcodes:
  - `000` ADD, `001` SUB, `010` AND, `011` OR, `101` SLT: ALU ops; `ULAControl` equals the opcode.
  - `100` LDI: rd <= imm8, no ALU use.
  - `110` NOP.
  - `111` illegal.
- FSM states and transitions:
  - IDLE: `InstrReady`=1. On `InstrValid`&`InstrReady`, latch `Instr` and go to DECODE. Otherwise stay.
  - DECODE: for ALU ops, `SrcA`<=regs[rs], `SrcB`<=regs[rt], `ULAControl`<=opcode. For non-ALU ops, these three hold their previous values. Go to EXEC.
  - EXEC: for ALU ops, capture `ULAResult` into a result register, `Z`<=`Flag_z`, `C`<=`CarryOut`. For LDI, result register <= imm8. For illegal, `Err`<=1. Go to WB.
  - WB: `Done`=1. For ALU ops and LDI, regs[rd] <= result register. NOP and illegal write nothing. Go to IDLE.
- Status updates:
  - `Z`/`C` update only on ALU ops; LDI, NOP and illegal leave them unchanged.
  - SLT sets C to whatever the ULA reports, which is 0.
- Register file:
  - Operands are read in DECODE, so rd may equal rs or rt with no hazard.
  - All four registers are writable.
- `Instr` changes and `InstrValid` while not in IDLE are ignored; there is no queuing.
- `Err` clears only on reset.

## Timing

- Handshake: transfer occurs on the rising edge where `InstrValid`&`InstrReady`=1. `InstrValid` may stay high; the controller re-accepts on the next IDLE cycle.
- Latency: with accept at edge N, the state is DECODE in cycle N..N+1, EXEC in N+1..N+2, and WB (`Done`=1) in N+2..N+3.
  - `RegData` reflects the write from edge N+3.
  - `InstrReady` is high again in the cycle after WB.
- Throughput: one instruction per 4 cycles with `InstrValid` held high.
- ULA is purely combinational; `SrcA`/`SrcB`/`ULAControl` are stable for the entire EXEC cycle.
- Reset:
  - On a rising edge with `rst_n`=0: FSM goes to IDLE; regs, `SrcA`, `SrcB`, `ULAControl`, `Z`, `C`, `Err`, `Done` and the result register all go to 0.
  - `InstrReady`=1 in the first cycle after release.
  - Reset mid-instruction aborts it: no `Done`, no register write.

## Test plan

- Reset, then LDI r1,0xC8; LDI r2,0x64; ADD r3,r1,r2 -> r3=0x2C, C=1, Z=0. `Done` pulses exactly 3 cycles after each accept.
- SUB r0,r2,r2 -> r0=0x00, Z=1, C=0. Then SUB r1,r2,r1 (0x64-0xC8) -> r1=0x9C, C=1, Z=0.
- With r1=0xC8, r2=0x64: SLT r3,r2,r1 -> r3=0x01, Z=0. SLT r3,r1,r2 -> r3=0x00, Z=1, C=0. AND r0,r1,r2 -> 0x40. OR r0,r1,r2 -> 0xEC.
- Opcode 111 -> `Err`=1, `Done` pulses, all regs and Z/C unchanged. A following LDI completes normally and `Err` stays 1 until reset.
- Hold `InstrValid`=1 across a stream of 3 instructions -> accepts exactly 4 cycles apart. `InstrReady`=0 in DECODE/EXEC/WB. Mid-instruction changes on `Instr` have no effect.
- Assert `rst_n`=0 for one edge during EXEC of ADD r2,... -> next cycle IDLE, all outputs 0, no `Done`, r2=0x00.
